// File: rtl/turn_state_if.sv
// Signal bundle between the push-buttons/brake switch, the controller and the
// dot-matrix picture stage.
// Handshake: there is no valid/ready pair. The key and brake inputs are raw
// asynchronous levels. en_all and state are registered levels that hold their
// value until the next change, so a consumer samples them at any time.
// turn_dbg mirrors the internal turn FSM state (00 off, 01 left, 10 right).
interface turn_state_if;
    logic       key_power;
    logic       key_left;
    logic       key_right;
    logic       sw_brake;
    logic       en_all;
    logic [1:0] state;
    logic [1:0] turn_dbg;

    modport master (
        output key_power, key_left, key_right, sw_brake,
        input  en_all, state, turn_dbg
    );

    modport slave (
        input  key_power, key_left, key_right, sw_brake,
        output en_all, state, turn_dbg
    );
endinterface

// File: rtl/turn_state_ctrl.sv
// Turn-signal / brake state controller.
// Four active-low inputs pass through synchronizers and debouncers. Key presses
// (debounced falling edges) drive a display enable toggle and a three-state
// turn FSM with an auto-cancel timeout. The brake level overrides the displayed
// mode without disturbing the turn FSM.
module turn_state_ctrl #(
    parameter int DEBOUNCE_CYCLES     = 20000,
    parameter int TURN_TIMEOUT_CYCLES = 30_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    turn_state_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = (TURN_TIMEOUT_CYCLES > 1) ? $clog2(TURN_TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TURN_TIMEOUT_CYCLES - 1);

    // Bit positions of the inputs inside the packed input vectors.
    localparam int K_POWER = 0;
    localparam int K_LEFT  = 1;
    localparam int K_RIGHT = 2;
    localparam int K_BRAKE = 3;

    typedef enum logic [1:0] {
        T_OFF   = 2'b00,
        T_LEFT  = 2'b01,
        T_RIGHT = 2'b10
    } turn_t;

    logic [3:0]      raw;
    logic [3:0]      sync_1;
    logic [3:0]      sync_2;
    logic [3:0]      clean;
    logic [3:0]      clean_d;
    logic [DB_W-1:0] db_cnt [4];

    logic            ev_power;
    logic            ev_left;
    logic            ev_right;
    logic            en_r;

    turn_t           turn_q;
    turn_t           turn_d;
    logic [TO_W-1:0] tmo_cnt;
    logic [TO_W-1:0] tmo_d;

    logic            en_q;
    logic [1:0]      state_q;

    assign raw = {bus.sw_brake, bus.key_right, bus.key_left, bus.key_power};

    // Two-flop synchronizers; reset to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 4'hF;
            sync_2 <= 4'hF;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Debounce: the clean level moves only after the synchronized level has
    // differed from it for DEBOUNCE_CYCLES consecutive cycles. Any return to
    // the clean level restarts the count. clean_d is the previous clean level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean   <= 4'hF;
            clean_d <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            clean_d <= clean;
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == clean[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    clean[i]  <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is a debounced 1->0 transition; releases produce nothing.
    assign ev_power = clean_d[K_POWER] & ~clean[K_POWER];
    assign ev_left  = clean_d[K_LEFT]  & ~clean[K_LEFT];
    assign ev_right = clean_d[K_RIGHT] & ~clean[K_RIGHT];

    // Display enable toggles on each power press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r <= 1'b0;
        end else if (ev_power) begin
            en_r <= ~en_r;
        end
    end

    // Turn FSM state register and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_q  <= T_OFF;
            tmo_cnt <= '0;
        end else begin
            turn_q  <= turn_d;
            tmo_cnt <= tmo_d;
        end
    end

    // Turn FSM next state. Power-off wins, then a single left/right event,
    // then the timeout. Simultaneous left+right events leave the state alone.
    // The timeout counter clears on entry, on any left/right event and in
    // T_OFF, and saturates at its terminal value.
    always_comb begin
        turn_d = turn_q;
        tmo_d  = tmo_cnt;
        if (ev_power && en_r) begin
            turn_d = T_OFF;
        end else if (ev_left ^ ev_right) begin
            case (turn_q)
                T_OFF:   turn_d = ev_left  ? T_LEFT : T_RIGHT;
                T_LEFT:  turn_d = ev_left  ? T_OFF  : T_RIGHT;
                T_RIGHT: turn_d = ev_right ? T_OFF  : T_LEFT;
                default: turn_d = T_OFF;
            endcase
        end else if ((turn_q != T_OFF) && (tmo_cnt == TO_LAST)) begin
            turn_d = T_OFF;
        end

        if ((turn_d == T_OFF) || ev_left || ev_right || (turn_d != turn_q)) begin
            tmo_d = '0;
        end else if (tmo_cnt != TO_LAST) begin
            tmo_d = tmo_cnt + 1'b1;
        end
    end

    // Registered outputs. Brake is taken from the delayed clean level so that
    // it reaches the output with the same latency as a key press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            state_q <= 2'b00;
        end else begin
            en_q    <= en_r;
            state_q <= (!clean_d[K_BRAKE]) ? 2'b11 : turn_q;
        end
    end

    assign bus.en_all   = en_q;
    assign bus.state    = state_q;
    assign bus.turn_dbg = turn_q;

endmodule

// File: tb/tb_turn_state_ctrl.sv
// Bench for turn_state_ctrl with short debounce/timeout parameters.
// Directed key sequences push the expected {en_all,state} value and the cycle
// it should appear at; a negedge monitor pops and compares on every output
// change, and any expectation still queued at the end is reported.
module tb_turn_state_ctrl;
    localparam int DB = 4;
    localparam int TO = 50;
    localparam int W  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    turn_state_if ifc();

    turn_state_ctrl #(
        .DEBOUNCE_CYCLES     (DB),
        .TURN_TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state.
    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];
    int           checks   = 0;
    int           errors   = 0;
    logic [W-1:0] last_out = '0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       ifc.key_power = v;
            1:       ifc.key_left  = v;
            2:       ifc.key_right = v;
            default: ifc.sw_brake  = v;
        endcase
    endtask

    task automatic press(input int k, input int hold);
        set_key(k, 1'b0);
        tick(hold);
        set_key(k, 1'b1);
    endtask

    task automatic expect_out(input logic en, input logic [1:0] st, input int at);
        exp_q.push_back({en, st});
        exp_t_q.push_back(at);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every change of {en_all,state} outside reset must match the
    // next queued expectation, in value and within one cycle of its time.
    always @(negedge clk) begin
        logic [W-1:0] now_out;
        logic [W-1:0] e;
        int           t;
        now_out = {ifc.en_all, ifc.state};
        if (!rst_n) begin
            last_out = '0;
        end else if (now_out != last_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: got=%b at cycle %0d, expected no change", now_out, cyc);
            end else begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check_val("out_value", int'(now_out), int'(e));
                checks++;
                if ((cyc < t - 1) || (cyc > t + 1)) begin
                    errors++;
                    $display("FAIL out_timing: changed at cycle %0d, expected %0d +/-1", cyc, t);
                end
            end
            last_out = now_out;
        end
    end

    // Stimulus.
    initial begin
        int p;
        int a;
        int r;
        int l;
        ifc.key_power = 1'b1;
        ifc.key_left  = 1'b1;
        ifc.key_right = 1'b1;
        ifc.sw_brake  = 1'b1;

        // Reset state.
        tick(2);
        check_val("reset_en_all", ifc.en_all, 0);
        check_val("reset_state", ifc.state, 0);
        check_val("reset_turn", ifc.turn_dbg, 0);
        rst_n = 1'b1;
        tick(3);

        // Power toggles on, off, on again.
        p = cyc; expect_out(1'b1, 2'b00, p + 8); press(0, 10); tick(12);
        p = cyc; expect_out(1'b0, 2'b00, p + 8); press(0, 10); tick(12);
        p = cyc; expect_out(1'b1, 2'b00, p + 8); press(0, 10); tick(12);

        // Bouncing left key: no event.
        for (int i = 0; i < 3; i++) begin
            press(1, 2);
            tick(1);
        end
        tick(10);

        // Clean left press, brake over it, right press under brake, brake
        // release shows right, then right times out 50 cycles after entry.
        a = cyc; expect_out(1'b1, 2'b01, a + 8); press(1, 10); tick(4);
        p = cyc; set_key(3, 1'b0); expect_out(1'b1, 2'b11, p + 8); tick(10);
        r = cyc; press(2, 10); tick(12);
        set_key(3, 1'b1);
        expect_out(1'b1, 2'b10, r + 30);
        expect_out(1'b1, 2'b00, r + 58);
        tick(40);

        // A left event 30 cycles into a right turn restarts the timeout.
        r = cyc; expect_out(1'b1, 2'b10, r + 8); press(2, 10); tick(20);
        l = cyc;
        expect_out(1'b1, 2'b01, l + 8);
        expect_out(1'b1, 2'b00, l + 58);
        press(1, 10); tick(52);

        // Left and right together from T_OFF: ignored.
        set_key(1, 1'b0); set_key(2, 1'b0); tick(10);
        set_key(1, 1'b1); set_key(2, 1'b1); tick(12);

        // Power off during a left turn forces T_OFF.
        a = cyc; expect_out(1'b1, 2'b01, a + 8); press(1, 10); tick(4);
        p = cyc; expect_out(1'b0, 2'b00, p + 8); press(0, 10); tick(12);

        // With display disabled the turn state is still tracked.
        r = cyc; expect_out(1'b0, 2'b10, r + 8); press(2, 10); tick(6);

        // Asynchronous reset mid-turn, with left held through reset.
        #2;
        rst_n = 1'b0;
        set_key(1, 1'b0);
        #1;
        check_val("midreset_en_all", ifc.en_all, 0);
        check_val("midreset_state", ifc.state, 0);
        check_val("midreset_turn", ifc.turn_dbg, 0);
        tick(3);
        rst_n = 1'b1;
        p = cyc; expect_out(1'b0, 2'b01, p + 8);
        tick(12);
        set_key(1, 1'b1);
        tick(12);

        // Anything still expected never showed up.
        for (int i = 0; (i < 20) && (exp_q.size() > 0); i++) begin
            tick(1);
        end
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_change: expected %b at cycle %0d, never seen", exp_q[0], exp_t_q[0]);
            void'(exp_q.pop_front());
            void'(exp_t_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
